mux_n_reg: RTL
==============

Name: mux_n_reg

Overview:
- Parametrised N-way, W-bit selector with a registered output stage and valid/ready handshake on both sides.
- Next-generation replacement for the single-bit 2:1 selector. Used where a pipeline stage picks one of several operand/result sources: writeback source, forwarding source, PC source.
- Two-entry skid buffer gives full throughput (1 transfer/cycle) with a registered in_ready, so no combinational ready path runs through the block.

Parameters:
- WIDTH, 32, bit width of each data input and of out_data
- NUM_IN, 4, number of selectable inputs; must be >= 2
- SEL_W, $clog2(NUM_IN), width of in_sel; derived, not overridden

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  index of the input to pass; sampled with in_valid
- in_valid  input  1  upstream has a transfer
- in_ready  output  1  block can accept; registered
- out_data  output  WIDTH  selected data, registered
- out_sel  output  SEL_W  in_sel value that produced out_data
- out_valid  output  1  out_data/out_sel valid
- out_ready  input  1  downstream accepts

Behaviour:
- Reset (async assert, sync-free deassert on clk): out_valid=0, out_data=0, out_sel=0, skid_valid=0, skid regs=0, in_ready=1.
- Accept: in_valid & in_ready at a rising edge. Emit: out_valid & out_ready at a rising edge.
- Selected value = in_data slice in_sel, captured at the accept edge.
- in_sel >= NUM_IN (non-power-of-two NUM_IN): selected value = all zeros.
- Latency: accepted data appears on out_data/out_valid the cycle after the accept edge.
- in_ready = ~skid_valid, driven from a flop.
- State = {out_valid, skid_valid}: EMPTY(0,0), ONE(1,0), FULL(1,1). (0,1) is unreachable.
- EMPTY + accept -> ONE, output regs loaded.
- ONE + accept + emit -> ONE, output regs reloaded with new data.
- ONE + accept, no emit -> FULL, skid loaded with new data, output held stable.
- ONE + emit, no accept -> EMPTY.
- FULL + emit -> ONE, output <- skid, skid cleared. No accept is possible since in_ready=0.
- FULL, no emit -> hold; out_data/out_sel stable while out_valid & ~out_ready.
- Ordering strictly FIFO; no transfer dropped or duplicated.
- in_valid while in_ready=0: ignored. Upstream holds its data.
- Reset mid-operation: any held/skid data discarded, state -> EMPTY immediately.

Optional Feature:
- Macro MUX_N_REG_SEL_CHECK_EN.
- Defined:
  - Extra port sel_err output 1.
  - Sticky flag set on any accept with in_sel >= NUM_IN.
  - Cleared only by rst_n.
  - Data path still forwards zeros.
- Undefined:
  - No sel_err port, no checking logic.
  - Out-of-range select silently forwards zeros.

Decomposition:
- Package mux_pkg:
  - skid state encoding constants (ST_EMPTY, ST_ONE, ST_FULL).
  - Default WIDTH/NUM_IN constants shared with datapath top.
- Sub-module mux_n_comb: purely combinational N-way WIDTH-bit select with zero for out-of-range index; instantiated once in front of the registers.
- Registers, skid buffer and handshake live in mux_n_reg.

Test Plan:
- Reset: rst_n=0 mid-stream with FULL state -> out_valid=0, in_ready=1, out_data=0 asynchronously, before the next clk edge.
- Single transfer: in_data={4,3,2,1}, in_sel=2, in_valid=1 for one cycle, out_ready=1 -> next cycle out_data=3, out_sel=2, out_valid=1 for one cycle.
- Back-to-back, out_ready=1: in_sel 0,1,2,3 on consecutive cycles -> out_data 1,2,3,4 on consecutive cycles; in_ready never drops.
- Backpressure: out_ready=0, send in_sel=0 then in_sel=3:
  - out_data holds 1, in_ready=0 after the second accept.
  - out_ready=1 -> out 1 then 4, in_ready returns to 1.
- Out-of-range: NUM_IN=3, in_sel=3 -> out_data=0; with MUX_N_REG_SEL_CHECK_EN sel_err=1 and stays 1 until reset.
- Random: random in_valid/out_ready/in_sel over 10k cycles vs. scoreboard queue -> no loss, duplication or reorder; out_data stable whenever out_valid & ~out_ready.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants for the registered N-way selector: default datapath sizes and
// the skid-buffer state encoding ({out_valid, skid_valid}).
package mux_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_NUM_IN = 4;

   // Encoding mirrors {out_valid, skid_valid}; 2'b01 can never be reached.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b10,
      ST_FULL  = 2'b11
   } skid_state_t;

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way, WIDTH-bit select; an index past the last input yields zero.
module mux_n_comb
   import mux_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        sel_data
);

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (int'(sel) == k) begin
            sel_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-way selector with a two-entry skid buffer and valid/ready on both sides.
// Optional MUX_N_REG_SEL_CHECK_EN adds a sticky sel_err flag for out-of-range selects.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_EMPTY | nothing held, out_valid=0, in_ready=1
// ST_ONE   | output register holds one transfer, in_ready=1
// ST_FULL  | output and skid registers both hold data, in_ready=0
module mux_n_reg
   import mux_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NUM_IN = DEF_NUM_IN,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef MUX_N_REG_SEL_CHECK_EN
   ,
   output logic                    sel_err
`endif
);

   skid_state_t      state;
   logic [WIDTH-1:0] sel_data;
   logic [WIDTH-1:0] skid_data;
   logic [SEL_W-1:0] skid_sel;
   logic             accept;
   logic             emit;

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;

   mux_n_comb #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_sel (
      .in_data  (in_data),
      .sel      (in_sel),
      .sel_data (sel_data)
   );

   // in_ready is its own flop so no ready path runs combinationally through here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         out_data  <= '0;
         out_sel   <= '0;
         skid_data <= '0;
         skid_sel  <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state     <= ST_ONE;
                  out_valid <= 1'b1;
                  out_data  <= sel_data;
                  out_sel   <= in_sel;
               end
            end
            ST_ONE: begin
               if (accept && emit) begin
                  out_data <= sel_data;
                  out_sel  <= in_sel;
               end else if (accept) begin
                  state     <= ST_FULL;
                  in_ready  <= 1'b0;
                  skid_data <= sel_data;
                  skid_sel  <= in_sel;
               end else if (emit) begin
                  state     <= ST_EMPTY;
                  out_valid <= 1'b0;
               end
            end
            ST_FULL: begin
               if (emit) begin
                  state     <= ST_ONE;
                  in_ready  <= 1'b1;
                  out_data  <= skid_data;
                  out_sel   <= skid_sel;
                  skid_data <= '0;
                  skid_sel  <= '0;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

`ifdef MUX_N_REG_SEL_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_err <= 1'b0;
      end else if (accept && (int'(in_sel) >= NUM_IN)) begin
         sel_err <= 1'b1;
      end
   end
`endif

endmodule
